// File: rtl/switch_allocator_if.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator_if
// Description : Bundle of the switch allocator's FIFO-side and link-side
//               signals.
//               FIFO side : in_valid[i], in_data[i] (head flit of input FIFO
//                           i), in_pop[i] (pop request back to FIFO i).
//               Link side : out_full[o] (downstream buffer almost full),
//                           out_valid[o] / out_data[o] (registered flit),
//                           drop_err (stray body flit discarded).
//               master = environment (FIFOs + links), slave = allocator.
// Revision    : 1.0 - initial release
// ============================================================================
interface switch_allocator_if;
  logic [4:0]       in_valid;
  logic [4:0][15:0] in_data;
  logic [4:0]       in_pop;
  logic [4:0]       out_full;
  logic [4:0]       out_valid;
  logic [4:0][15:0] out_data;
  logic             drop_err;

  modport master (
    output in_valid, in_data, out_full,
    input  in_pop, out_valid, out_data, drop_err
  );

  modport slave (
    input  in_valid, in_data, out_full,
    output in_pop, out_valid, out_data, drop_err
  );
endinterface
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator
// Description : Five-port wormhole switch allocator for a 2D mesh router.
//               XY-routes head flits, runs one round-robin arbiter per
//               output, holds a lock from head to tail, pops the input FIFOs
//               and registers the granted flit onto the output link.
// Ports       : clk     - clock
//               rst     - synchronous active-high reset
//               io_bus  - switch_allocator_if.slave:
//                         in_valid/in_data (FIFO heads), in_pop (comb),
//                         out_full, out_valid/out_data (registered),
//                         drop_err (comb pulse, stray body flit dropped)
// Port map    : 0 local, 1 +X, 2 -X, 3 +Y, 4 -Y
// Flit        : [15] head, [14] tail, [13:11] dest X, [10:8] dest Y, [7:0] data
// Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator #(
  parameter logic [2:0] NODE_X    = 3'd0,
  parameter logic [2:0] NODE_Y    = 3'd0,
  parameter int         NUM_PORTS = 5
) (
  input  logic              clk,
  input  logic              rst,
  switch_allocator_if.slave io_bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Per-output arbitration state
  state_e     r_state     [NUM_PORTS];
  state_e     w_state_nxt [NUM_PORTS];
  logic [2:0] r_owner     [NUM_PORTS];
  logic [2:0] w_owner_nxt [NUM_PORTS];
  logic [2:0] r_rr        [NUM_PORTS];
  logic [2:0] w_rr_nxt    [NUM_PORTS];

  // Per-input latched route (valid while the input owns an output)
  logic [NUM_PORTS-1:0] r_in_lock;
  logic [2:0]           r_in_route [NUM_PORTS];

  // Registered output link
  logic [NUM_PORTS-1:0]       r_out_valid;
  logic [NUM_PORTS-1:0][15:0] r_out_data;

  // Combinational request / grant signals
  logic [2:0]           w_hroute   [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_head_req [NUM_PORTS];  // [o] = inputs bidding a head for o
  logic [NUM_PORTS-1:0] w_lock_req [NUM_PORTS];  // [o] = locked inputs targeting o
  logic [NUM_PORTS-1:0] w_gnt_v;
  logic [2:0]           w_gnt_idx  [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_drop;
  logic [NUM_PORTS-1:0] w_pop;
  logic [NUM_PORTS-1:0] w_lock_set;
  logic [NUM_PORTS-1:0] w_lock_clr;
  logic [2:0]           w_set_route [NUM_PORTS];

  // Dimension-order route: resolve X first, then Y, else eject locally.
  function automatic logic [2:0] xy_route(input logic [15:0] flit);
    if (flit[13:11] > NODE_X)      return 3'd1;
    else if (flit[13:11] < NODE_X) return 3'd2;
    else if (flit[10:8] > NODE_Y)  return 3'd3;
    else if (flit[10:8] < NODE_Y)  return 3'd4;
    else                           return 3'd0;
  endfunction

  // (a + b) mod 5 for a, b in 0..4
  function automatic logic [2:0] wrap_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 4'd5) sum = sum - 4'd5;
    return sum[2:0];
  endfunction

  // --------------------------------------------------------------------------
  // Request generation
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_hroute[i] = xy_route(io_bus.in_data[i]);
      // A body/tail flit with no owning route can never be delivered.
      w_drop[i]   = !rst && io_bus.in_valid[i] && !r_in_lock[i] && !io_bus.in_data[i][15];
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_head_req[o][i] = io_bus.in_valid[i] && !r_in_lock[i] &&
                           io_bus.in_data[i][15] && (w_hroute[i] == 3'(o));
        w_lock_req[o][i] = io_bus.in_valid[i] && r_in_lock[i] &&
                           (r_in_route[i] == 3'(o));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-output arbitration and next-state
  // --------------------------------------------------------------------------
  always_comb begin
    logic [2:0]  v_cand;
    logic        v_found;
    logic [15:0] v_flit;

    v_cand     = 3'd0;
    v_found    = 1'b0;
    v_flit     = 16'h0000;
    w_lock_set = '0;
    w_lock_clr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_set_route[i] = 3'd0;
    end

    for (int o = 0; o < NUM_PORTS; o++) begin
      w_gnt_v[o]     = 1'b0;
      w_gnt_idx[o]   = 3'd0;
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      w_rr_nxt[o]    = r_rr[o];
      v_found        = 1'b0;

      if (!rst && !io_bus.out_full[o]) begin
        case (r_state[o])
          ST_LOCKED: begin
            // Only the owner may use a locked output.
            if (w_lock_req[o][r_owner[o]]) begin
              w_gnt_v[o]   = 1'b1;
              w_gnt_idx[o] = r_owner[o];
            end
          end
          default: begin
            // First bidder at or after the round-robin pointer.
            for (int k = 0; k < NUM_PORTS; k++) begin
              v_cand = wrap_add(r_rr[o], 3'(k));
              if (!v_found && w_head_req[o][v_cand]) begin
                v_found      = 1'b1;
                w_gnt_v[o]   = 1'b1;
                w_gnt_idx[o] = v_cand;
              end
            end
          end
        endcase
      end

      if (w_gnt_v[o]) begin
        v_flit = io_bus.in_data[w_gnt_idx[o]];
        if (r_state[o] == ST_IDLE) begin
          w_rr_nxt[o] = wrap_add(w_gnt_idx[o], 3'd1);
          if (!v_flit[14]) begin
            // Multi-flit packet: hold the output until the tail passes.
            w_state_nxt[o]              = ST_LOCKED;
            w_owner_nxt[o]              = w_gnt_idx[o];
            w_lock_set[w_gnt_idx[o]]    = 1'b1;
            w_set_route[w_gnt_idx[o]]   = 3'(o);
          end
        end else if (v_flit[14]) begin
          w_state_nxt[o]           = ST_IDLE;
          w_lock_clr[w_gnt_idx[o]] = 1'b1;
        end
      end
    end

    w_pop = w_drop;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (w_gnt_v[o]) w_pop[w_gnt_idx[o]] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (rst) begin
        r_state[o] <= ST_IDLE;
        r_owner[o] <= 3'd0;
        r_rr[o]    <= 3'd0;
      end else begin
        r_state[o] <= w_state_nxt[o];
        r_owner[o] <= w_owner_nxt[o];
        r_rr[o]    <= w_rr_nxt[o];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rst || w_lock_clr[i]) begin
        r_in_lock[i]  <= 1'b0;
        r_in_route[i] <= 3'd0;
      end else if (w_lock_set[i]) begin
        r_in_lock[i]  <= 1'b1;
        r_in_route[i] <= w_set_route[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= '0;
      r_out_data  <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_out_valid[o] <= w_gnt_v[o];
        if (w_gnt_v[o]) r_out_data[o] <= io_bus.in_data[w_gnt_idx[o]];
      end
    end
  end

  assign io_bus.in_pop    = w_pop;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.drop_err  = |w_drop;

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_allocator
// Description : Directed, table-driven bench for switch_allocator at node
//               (2,2). Each table row drives one cycle of inputs, checks the
//               combinational pop/drop, then the registered outputs after the
//               clock edge. Reset mid-packet is a hand-written sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  switch_allocator_if sw_if ();

  switch_allocator #(
    .NODE_X    (3'd2),
    .NODE_Y    (3'd2),
    .NUM_PORTS (5)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (sw_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]       iv;
    logic [4:0]       of;
    logic [4:0][15:0] d;
    logic [4:0]       pop;
    logic             drop;
    logic [4:0]       ov;
    logic [4:0][15:0] od;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [4:0] iv, input logic [4:0] of, input logic [79:0] d,
                     input logic [4:0] pop, input logic drop,
                     input logic [4:0] ov, input logic [79:0] od);
    vec_t v;
    v.iv = iv; v.of = of; v.d = d;
    v.pop = pop; v.drop = drop; v.ov = ov; v.od = od;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, id, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] iv, input logic [4:0] of, input logic [79:0] d);
    sw_if.in_valid = iv;
    sw_if.out_full = of;
    sw_if.in_data  = d;
  endtask

  task automatic step(input vec_t v, input int id);
    drive(v.iv, v.of, v.d);
    #1;
    chk("pop",  id, 32'(sw_if.in_pop),   32'(v.pop));
    chk("drop", id, 32'(sw_if.drop_err), 32'(v.drop));
    @(posedge clk); #1;
    chk("out_valid", id, 32'(sw_if.out_valid), 32'(v.ov));
    for (int o = 0; o < 5; o++) begin
      if (v.ov[o]) chk("out_data", id, 32'(sw_if.out_data[o]), 32'(v.od[o]));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(5'b0, 5'b0, '0);

    // ---- table (data ordered {port4, port3, port2, port1, port0}) ----
    // idle
    add(5'b00000, 5'b00000, '0, 5'b00000, 1'b0, 5'b00000, '0);
    // single local delivery
    add(5'b00001, 5'b00000, {16'h0, 16'h0, 16'h0, 16'h0, 16'hD2AB},
        5'b00001, 1'b0, 5'b00001, {16'h0, 16'h0, 16'h0, 16'h0, 16'hD2AB});
    // XY routing: (3,0)->1, (1,3)->2, (2,3)->3, (2,1)->4
    add(5'b01111, 5'b00000, {16'h0, 16'hD144, 16'hD333, 16'hCB22, 16'hD811},
        5'b01111, 1'b0, 5'b11110, {16'hD144, 16'hD333, 16'hCB22, 16'hD811, 16'h0});
    // round robin on output 0 (pointer now 1): 1,2,3,1,2,3
    for (int r = 0; r < 6; r++) begin
      case (r % 3)
        0: add(5'b01110, 5'b0, {16'h0, 16'hD2A3, 16'hD2A2, 16'hD2A1, 16'h0},
               5'b00010, 1'b0, 5'b00001, {64'h0, 16'hD2A1});
        1: add(5'b01110, 5'b0, {16'h0, 16'hD2A3, 16'hD2A2, 16'hD2A1, 16'h0},
               5'b00100, 1'b0, 5'b00001, {64'h0, 16'hD2A2});
        default: add(5'b01110, 5'b0, {16'h0, 16'hD2A3, 16'hD2A2, 16'hD2A1, 16'h0},
               5'b01000, 1'b0, 5'b00001, {64'h0, 16'hD2A3});
      endcase
    end
    // stray body flit at unlocked input 4
    add(5'b10000, 5'b00000, {16'h0005, 64'h0}, 5'b10000, 1'b1, 5'b00000, '0);
    // full output blocks a single-flit grant, then it goes
    add(5'b00001, 5'b00001, {64'h0, 16'hD2AB}, 5'b00000, 1'b0, 5'b00000, '0);
    add(5'b00001, 5'b00000, {64'h0, 16'hD2AB}, 5'b00001, 1'b0, 5'b00001, {64'h0, 16'hD2AB});
    // wormhole: input 2 head/body/tail to +X, input 3 head waits
    add(5'b01100, 5'b00000, {16'h0, 16'hD8B3, 16'h9801, 32'h0},
        5'b00100, 1'b0, 5'b00010, {48'h0, 16'h9801, 16'h0});
    add(5'b01100, 5'b00000, {16'h0, 16'hD8B3, 16'h0002, 32'h0},
        5'b00100, 1'b0, 5'b00010, {48'h0, 16'h0002, 16'h0});
    // backpressure for three cycles before the tail
    for (int r = 0; r < 3; r++) begin
      add(5'b01100, 5'b00010, {16'h0, 16'hD8B3, 16'h4003, 32'h0},
          5'b00000, 1'b0, 5'b00000, '0);
    end
    add(5'b01100, 5'b00000, {16'h0, 16'hD8B3, 16'h4003, 32'h0},
        5'b00100, 1'b0, 5'b00010, {48'h0, 16'h4003, 16'h0});
    // lock released: input 3 wins the cycle after the tail
    add(5'b01000, 5'b00000, {16'h0, 16'hD8B3, 48'h0},
        5'b01000, 1'b0, 5'b00010, {48'h0, 16'hD8B3, 16'h0});
    // U-turn: head arriving on +X routed back out +X
    add(5'b00010, 5'b00000, {48'h0, 16'hD8C1, 16'h0},
        5'b00010, 1'b0, 5'b00010, {48'h0, 16'hD8C1, 16'h0});
    add(5'b00000, 5'b00000, '0, 5'b00000, 1'b0, 5'b00000, '0);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 0, 32'(sw_if.out_valid), 32'h0);
    chk("rst_drop",      0, 32'(sw_if.drop_err),  32'h0);
    for (int o = 0; o < 5; o++) chk("rst_out_data", o, 32'(sw_if.out_data[o]), 32'h0);
    rst = 1'b0;

    foreach (tbl[n]) step(tbl[n], n + 1);

    // ---- reset mid-packet ----
    // head (2,3) from input 0 locks output 3
    drive(5'b00001, 5'b0, {64'h0, 16'h9377});
    #1;
    chk("mid_pop", 100, 32'(sw_if.in_pop), 32'h01);
    @(posedge clk); #1;
    chk("mid_out_valid", 100, 32'(sw_if.out_valid), 32'h08);
    chk("mid_out_data",  100, 32'(sw_if.out_data[3]), 32'h9377);
    // reset while the body waits
    drive(5'b00001, 5'b0, {64'h0, 16'h0078});
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_out_valid", 101, 32'(sw_if.out_valid), 32'h0);
    for (int o = 0; o < 5; o++) chk("rst2_out_data", 101, 32'(sw_if.out_data[o]), 32'h0);
    rst = 1'b0;
    // the residual body is now at an unlocked input and is dropped
    #1;
    chk("resid_pop",  102, 32'(sw_if.in_pop),   32'h01);
    chk("resid_drop", 102, 32'(sw_if.drop_err), 32'h1);
    @(posedge clk); #1;
    chk("resid_out_valid", 102, 32'(sw_if.out_valid), 32'h0);
    // pointers cleared: input 0 beats input 1 for output 0
    drive(5'b00011, 5'b0, {48'h0, 16'hD2E1, 16'hD2E0});
    #1;
    chk("rrclr_pop", 103, 32'(sw_if.in_pop), 32'h01);
    @(posedge clk); #1;
    chk("rrclr_out_valid", 103, 32'(sw_if.out_valid), 32'h01);
    chk("rrclr_out_data",  103, 32'(sw_if.out_data[0]), 32'hD2E0);

    drive(5'b0, 5'b0, '0);
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Sequences the five per-port input FIFOs of a 5-port mesh router onto five output links.
- Each cycle, computes XY routes for head flits at the FIFO fronts and runs one round-robin arbiter per output.
- Holds a wormhole lock from head flit to tail flit, issues FIFO pops, and drives registered output flits to the downstream links.
- Sits between the input FIFO array and the link converters inside each mesh node.

Parameters:
- NODE_X, 0, this node's X coordinate (3-bit range)
- NODE_Y, 0, this node's Y coordinate (3-bit range)
- NUM_PORTS, 5, number of ports; fixed at 5, other values unsupported

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  5  bit i: FIFO i head flit valid
- in_data  in  5x16  FIFO i head flit
- in_pop  out  5  bit i: pop FIFO i this cycle (combinational)
- out_full  in  5  bit o: downstream buffer on output o full
- out_valid  out  5  bit o: flit presented on output o (registered)
- out_data  out  5x16  output o flit (registered)
- drop_err  out  1  one-cycle pulse: non-head flit dropped at an unlocked input

Behaviour:
- Port map: 0 local, 1 +X, 2 -X, 3 +Y, 4 -Y.
- Flit format: [15] head, [14] tail, [13:11] dest X, [10:8] dest Y (head only), [7:0] payload. A flit with head=tail=1 is a single-flit packet.
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, drop_err=0; all output locks cleared; all round-robin pointers=0; all input route registers cleared.
- XY route of a head flit, evaluated combinationally:
  - destX>NODE_X -> 1; destX<NODE_X -> 2
  - else destY>NODE_Y -> 3; destY<NODE_Y -> 4
  - else 0
  - Comparisons are unsigned 3-bit.
- Input request:
  - Input i with in_valid and an unlocked route requests route(head).
  - Input i whose route is locked to output o requests o for any flit.
  - A non-head flit at an unlocked input is popped the same cycle with drop_err=1, and makes no request.
- Per-output state machine, states IDLE and LOCKED(owner):
  - IDLE: among inputs presenting a head flit for o, grant the first at or after rr_ptr[o] (cyclic 0..4). Grant only if out_full[o]=0.
  - On a head-only grant (tail=0): go to LOCKED(winner), rr_ptr[o] = (winner+1) mod 5, latch input route.
  - On a single-flit grant: stay IDLE, still advance rr_ptr[o].
  - LOCKED: owner's flit is granted whenever in_valid[owner] and out_full[o]=0; all other inputs are ignored.
  - Grant of the tail flit: return to IDLE next cycle and clear the input route. A new head may win o no earlier than the following cycle.
- Grant effects:
  - Same cycle: in_pop[i]=1.
  - Next cycle: out_valid[o]=1, out_data[o]=flit. Latency is 1 cycle from pop to output.
  - Otherwise out_valid[o]=0 next cycle; out_data holds its last value.
- Flow control:
  - out_full is sampled in the grant cycle.
  - Downstream must assert full with at least one free slot so the registered flit is never lost.
  - A stalled locked packet keeps its lock indefinitely.
- Concurrency:
  - Each input is granted by at most one output per cycle; each output grants at most one input per cycle.
  - Different outputs grant independently in the same cycle.
- U-turns: a route equal to the arrival port is legal and is routed normally.
- Reset mid-packet: all locks, routes and pointers are cleared. Residual body flits later appear at unlocked inputs and are dropped with drop_err.

Test Plan:
- Single local delivery: NODE=(2,2), input 0 presents 16'hD2AB (head+tail, dest (2,2)) → in_pop[0]=1 same cycle; next cycle out_valid[0]=1, out_data[0]=16'hD2AB; rr_ptr[0]=1.
- XY routing: NODE=(2,2), heads single-flit to dests (3,0), (1,3), (2,3), (2,1) on inputs 0-3 in the same cycle → outputs 1, 2, 3, 4 respectively all valid next cycle.
- Round-robin: inputs 1, 2, 3 each hold repeated single-flit packets to output 0, rr_ptr=0 → grant order 1, 2, 3, 1, 2, 3 on consecutive cycles.
- Wormhole lock: input 2 sends head/body/tail to output 1 while input 3 presents a head to output 1 → input 3 is ungranted until the cycle after the tail grant, and then wins.
- Backpressure: out_full[1]=1 for 3 cycles mid-packet → no in_pop, out_valid[1]=0 for those cycles; flits resume in order with nothing lost or duplicated.
- Error and reset: body flit 16'h0005 at an unlocked input 4 → popped with drop_err=1 for one cycle. Assert rst mid-packet → all outputs 0 next cycle and locks cleared.
